calc_seq_ctrl: RTL
==================

Name: calc_seq_ctrl

Overview:
- Sequencing controller for the 6-bit four-function calculator datapath (add/sub/mul/div).
- Accepts one operation request at a time over a valid/ready handshake and runs it: add, sub and mul in a single registered cycle, div as an iterative restoring divider taking DATA_W cycles.
- Holds the result until the consumer takes it.
- Sits between a command source (e.g. a UART/keypad decoder) and the result display/consumer logic.

Parameters:
- DATA_W, 6, operand width; result width is 2*DATA_W; division iteration count equals DATA_W.

Ports:
- i_clk  input  1  system clock; all logic is rising-edge.
- i_rst  input  1  reset; one clock; reset is synchronous and active-high.
- i_valid  input  1  request valid.
- o_ready  output  1  controller can accept a request (high only in IDLE).
- i_op  input  2  opcode: 0=add, 1=sub, 2=mul, 3=div.
- i_data1  input  DATA_W  operand 1 / dividend.
- i_data2  input  DATA_W  operand 2 / divisor.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts the result.
- o_result  output  2*DATA_W  result (zero-extended sum/difference, product, or quotient).
- o_rem  output  DATA_W  remainder for div; 0 for other ops.
- o_busy  output  1  high in EXEC or DIV.

Behaviour:
- Reset (i_rst=1 at a clock edge): state=IDLE; o_valid=0, o_result=0, o_rem=0, o_busy=0; o_ready=1 from the first cycle after reset releases.
- Reset mid-operation aborts any in-flight op; no result is produced.
- Request accepted at edge T when i_valid & o_ready. Opcode and operands are captured into internal registers; later input changes have no effect.
- States: IDLE, EXEC, DIV, DONE.
- IDLE, on accept:
  - add/sub/mul -> EXEC.
  - div with i_data2 != 0 -> DIV.
  - div with i_data2 == 0 -> EXEC (divide-by-zero path).
- EXEC (one cycle): compute and register the result -> DONE. o_valid=1 from cycle T+2, i.e. visible after the second edge.
- Arithmetic/width rules:
  - add: (DATA_W+1)-bit sum, zero-extended.
  - sub: (DATA_W+1)-bit two's-complement difference, modulo 2^(DATA_W+1), zero-extended.
  - mul: full 2*DATA_W-bit unsigned product.
  - o_rem = 0 for add, sub and mul.
- Divide-by-zero: quotient = all ones (DATA_W bits, zero-extended); o_rem = dividend.
- DIV: restoring shift-subtract, one quotient bit per cycle, MSB first; DATA_W cycles.
  - Iteration counter counts DATA_W-1 down to 0; leaves DIV to DONE when the counter hits 0.
  - o_valid is high DATA_W+1 cycles after accept.
  - o_result = unsigned quotient, zero-extended; o_rem = unsigned remainder.
- DONE: o_valid=1; o_result and o_rem held stable.
  - On i_ready=1: o_valid drops next cycle, state -> IDLE, o_ready=1 next cycle.
  - i_ready=0 stalls indefinitely.
  - Accept and result handshake never occur in the same cycle (one op in flight).
- i_valid while o_ready=0 is ignored; the source must hold the request until accepted.
- i_ready while o_valid=0 has no effect.
- Output timing: o_ready and o_busy are decoded from registered state; o_valid, o_result and o_rem are registers.

Optional Feature:
- Macro CALC_DIV_ZERO_FLAG_EN.
- Defined: adds output port o_div_zero (1 bit). It is registered, set with o_valid for a divide-by-zero op, cleared on result handshake and on reset.
- Not defined: port absent. Divide-by-zero still returns quotient all ones and remainder = dividend, with the same latency.

Test Plan:
- Reset for 2 cycles, release: o_ready=1, o_valid=0, o_result=0, o_rem=0, o_busy=0.
- add 63+63, i_ready=1: o_valid exactly 2 edges after accept, o_result=126, o_rem=0.
- sub 5-9, then mul 63*63: sub gives o_result=124 (7-bit wrap of -4); mul gives o_result=3969.
- div 45/7 accepted at T: o_busy high for 6 cycles, o_valid at T+7, o_result=6, o_rem=3. Hold i_ready=0 for 5 cycles: outputs stable; i_valid pulses during the stall are ignored.
- div 20/0: o_valid after 2 edges, o_result=63, o_rem=20; o_div_zero=1 when CALC_DIV_ZERO_FLAG_EN is defined.
- Start div 60/1, assert i_rst in the 3rd DIV cycle: next cycle state=IDLE, o_valid=0, o_busy=0, all outputs 0. The next add 1+2 returns 3.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: sequencing controller for the four-function calculator datapath.
// Accepts one request at a time (valid/ready), runs add/sub/mul in one registered
// cycle or div as a DATA_W-cycle restoring divider, then holds the result until
// the consumer takes it.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid/o_ready       request handshake; i_op, i_data1, i_data2 request payload
//   o_valid/i_ready       result handshake; o_result, o_rem result payload
//   o_busy                operation executing (EXEC or DIV)
//   o_div_zero            only with CALC_DIV_ZERO_FLAG_EN: result came from a divide by zero
module calc_seq_ctrl #(
  parameter int unsigned DATA_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [1:0]            i_op,
  input  logic [DATA_W-1:0]     i_data1,
  input  logic [DATA_W-1:0]     i_data2,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2*DATA_W-1:0]   o_result,
  output logic [DATA_W-1:0]     o_rem,
  output logic                  o_busy
`ifdef CALC_DIV_ZERO_FLAG_EN
  ,
  output logic                  o_div_zero
`endif
);

  localparam int unsigned RES_W = 2 * DATA_W;
  localparam int unsigned SUM_W = DATA_W + 1;
  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [1:0]          r_op;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_quo;
  logic [DATA_W-1:0]   r_prem;
  logic [CNT_W-1:0]    r_cnt;
  logic [RES_W-1:0]    r_result;
  logic [DATA_W-1:0]   r_rem;
  logic                r_valid;

  logic                w_accept;
  logic [SUM_W-1:0]    w_sum;
  logic [SUM_W-1:0]    w_diff;
  logic [RES_W-1:0]    w_prod;
  logic [RES_W-1:0]    w_exec_res;
  logic [DATA_W-1:0]   w_exec_rem;
  logic [SUM_W-1:0]    w_shift;
  logic                w_ge;
  logic [DATA_W-1:0]   w_sub;
  logic [DATA_W-1:0]   w_prem_nxt;
  logic [DATA_W-1:0]   w_quo_nxt;

  assign w_accept = i_valid && (r_state == S_IDLE);

  // Single-cycle arithmetic on the captured operands
  assign w_sum  = SUM_W'(r_a) + SUM_W'(r_b);
  assign w_diff = SUM_W'(r_a) - SUM_W'(r_b);
  assign w_prod = RES_W'(r_a) * RES_W'(r_b);

  // EXEC result select; a div reaching EXEC always has a zero divisor
  always_comb begin
    w_exec_res = '0;
    w_exec_rem = '0;
    case (r_op)
      OP_ADD:  w_exec_res = RES_W'(w_sum);
      OP_SUB:  w_exec_res = RES_W'(w_diff);
      OP_MUL:  w_exec_res = w_prod;
      default: begin
        w_exec_res = RES_W'({DATA_W{1'b1}});
        w_exec_rem = r_a;
      end
    endcase
  end

  // Restoring divide step: shift the next dividend bit into the partial remainder.
  // The partial remainder stays below the divisor, so a successful subtract fits DATA_W bits.
  assign w_shift    = {r_prem, r_quo[DATA_W-1]};
  assign w_ge       = (w_shift >= SUM_W'(r_b));
  assign w_sub      = w_shift[DATA_W-1:0] - r_b;
  assign w_prem_nxt = w_ge ? w_sub : w_shift[DATA_W-1:0];
  assign w_quo_nxt  = {r_quo[DATA_W-2:0], w_ge};

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if ((i_op == OP_DIV) && (i_data2 != '0)) w_state_nxt = S_DIV;
          else                                     w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: w_state_nxt = S_DONE;
      S_DIV:  if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE: if (i_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, divider iteration and result registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_quo    <= '0;
      r_prem   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_rem    <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= i_op;
            r_a    <= i_data1;
            r_b    <= i_data2;
            r_quo  <= i_data1;
            r_prem <= '0;
            r_cnt  <= CNT_W'(DATA_W - 1);
          end
        end
        S_EXEC: begin
          r_result <= w_exec_res;
          r_rem    <= w_exec_rem;
          r_valid  <= 1'b1;
        end
        S_DIV: begin
          r_quo  <= w_quo_nxt;
          r_prem <= w_prem_nxt;
          if (r_cnt == '0) begin
            r_result <= RES_W'(w_quo_nxt);
            r_rem    <= w_prem_nxt;
            r_valid  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (i_ready) r_valid <= 1'b0;
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

`ifdef CALC_DIV_ZERO_FLAG_EN
  logic r_div_zero;

  // Raised together with o_valid for a zero-divisor div, dropped on the result handshake
  always_ff @(posedge i_clk) begin
    if (i_rst)                                 r_div_zero <= 1'b0;
    else if ((r_state == S_EXEC) && (r_op == OP_DIV)) r_div_zero <= 1'b1;
    else if ((r_state == S_DONE) && i_ready)   r_div_zero <= 1'b0;
  end

  assign o_div_zero = r_div_zero;
`endif

  assign o_ready  = (r_state == S_IDLE);
  assign o_busy   = (r_state == S_EXEC) || (r_state == S_DIV);
  assign o_valid  = r_valid;
  assign o_result = r_result;
  assign o_rem    = r_rem;

endmodule
